// File: rtl/rx_pkt_ctrl.sv
// Receive packet controller: tracks one packet from preamble to FCS, runs the header/packet
// watchdogs, issues a timed receiver reset on failures and keeps ok/fail statistics.
module rx_pkt_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int TIMER_WIDTH = 20,
    parameter int RST_CYCLES  = 4
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    input  logic                   enable,
    input  logic                   sw_abort,
    input  logic                   cnt_clr,
    input  logic                   long_preamble_detected,
    input  logic                   pkt_header_valid_strobe,
    input  logic                   pkt_header_valid,
    input  logic                   ht_unsupport,
    input  logic                   fcs_out_strobe,
    input  logic                   fcs_ok,
    input  logic [15:0]            pkt_len,
    input  logic [15:0]            byte_count,
    input  logic [TIMER_WIDTH-1:0] hdr_timeout_th,
    input  logic [TIMER_WIDTH-1:0] pkt_timeout_th,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   pkt_start,
    output logic                   pkt_done,
    output logic [2:0]             pkt_status,
    output logic [CNT_WIDTH-1:0]   ok_cnt,
    output logic [CNT_WIDTH-1:0]   fail_cnt
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    localparam logic [2:0] ST_OK       = 3'd1;
    localparam logic [2:0] ST_FCS_FAIL = 3'd2;
    localparam logic [2:0] ST_HDR_BAD  = 3'd3;
    localparam logic [2:0] ST_HDR_TO   = 3'd4;
    localparam logic [2:0] ST_PKT_TO   = 3'd5;
    localparam logic [2:0] ST_ABORT    = 3'd6;
    localparam logic [2:0] ST_LEN_ERR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_HDR = 2'd1,
        RECV     = 2'd2,
        RST      = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [15:0]            r_pkt_len;
    logic [RC_W-1:0]        r_rst_cnt;
    logic                   r_core_rst;
    logic                   r_busy;
    logic                   r_pkt_start;
    logic                   r_pkt_done;
    logic [2:0]             r_pkt_status;
    logic [CNT_WIDTH-1:0]   r_ok_cnt;
    logic [CNT_WIDTH-1:0]   r_fail_cnt;

    logic       w_hdr_good;
    logic       w_hdr_to;
    logic       w_pkt_to;
    logic       w_rst_last;
    logic       w_start_nxt;
    logic       w_done_nxt;
    logic [2:0] w_status_nxt;
    logic       w_clr_timer;
    logic       w_ok_inc;
    logic       w_fail_inc;

    assign w_hdr_good = pkt_header_valid & ~ht_unsupport & (pkt_len != 16'd0);
    // A zero threshold disables the corresponding watchdog.
    assign w_hdr_to   = (hdr_timeout_th != '0) && (r_timer == hdr_timeout_th);
    assign w_pkt_to   = (pkt_timeout_th != '0) && (r_timer == pkt_timeout_th);
    assign w_rst_last = (r_rst_cnt == RST_LAST);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (sw_abort)                                w_state_nxt = RST;
                else if (long_preamble_detected && enable)   w_state_nxt = WAIT_HDR;
            end
            WAIT_HDR: begin
                if (sw_abort)                                w_state_nxt = RST;
                else if (pkt_header_valid_strobe)            w_state_nxt = w_hdr_good ? RECV : RST;
                else if (w_hdr_to)                           w_state_nxt = RST;
            end
            RECV: begin
                if (sw_abort)                                w_state_nxt = RST;
                else if (fcs_out_strobe)                     w_state_nxt = IDLE;
                else if (w_pkt_to)                           w_state_nxt = RST;
            end
            RST: begin
                if (w_rst_last)                              w_state_nxt = IDLE;
            end
            default:                                         w_state_nxt = IDLE;
        endcase
    end

    // Next values of the pulse/status outputs; abort outranks every other event.
    always_comb begin
        w_start_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_status_nxt = r_pkt_status;
        case (r_state)
            WAIT_HDR: begin
                if (sw_abort) begin
                    w_done_nxt   = 1'b1;
                    w_status_nxt = ST_ABORT;
                end else if (pkt_header_valid_strobe) begin
                    if (w_hdr_good) begin
                        w_start_nxt = 1'b1;
                    end else begin
                        w_done_nxt   = 1'b1;
                        w_status_nxt = ST_HDR_BAD;
                    end
                end else if (w_hdr_to) begin
                    w_done_nxt   = 1'b1;
                    w_status_nxt = ST_HDR_TO;
                end
            end
            RECV: begin
                if (sw_abort) begin
                    w_done_nxt   = 1'b1;
                    w_status_nxt = ST_ABORT;
                end else if (fcs_out_strobe) begin
                    w_done_nxt = 1'b1;
                    if (byte_count != r_pkt_len) w_status_nxt = ST_LEN_ERR;
                    else if (fcs_ok)             w_status_nxt = ST_OK;
                    else                         w_status_nxt = ST_FCS_FAIL;
                end else if (w_pkt_to) begin
                    w_done_nxt   = 1'b1;
                    w_status_nxt = ST_PKT_TO;
                end
            end
            default: ;
        endcase
    end

    assign w_clr_timer = ((r_state == IDLE) && (w_state_nxt == WAIT_HDR)) || w_start_nxt;
    assign w_ok_inc    = w_done_nxt && (w_status_nxt == ST_OK);
    assign w_fail_inc  = w_done_nxt && (w_status_nxt != ST_OK);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_core_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_status <= 3'd0;
            r_ok_cnt     <= '0;
            r_fail_cnt   <= '0;
            r_timer      <= '0;
            r_rst_cnt    <= '0;
        end else begin
            r_core_rst   <= (w_state_nxt == RST);
            r_busy       <= (w_state_nxt == WAIT_HDR) || (w_state_nxt == RECV);
            r_pkt_start  <= w_start_nxt;
            r_pkt_done   <= w_done_nxt;
            r_pkt_status <= w_status_nxt;

            if (cnt_clr) begin
                r_ok_cnt   <= '0;
                r_fail_cnt <= '0;
            end else begin
                if (w_ok_inc && (r_ok_cnt != '1))     r_ok_cnt   <= r_ok_cnt + CNT_WIDTH'(1);
                if (w_fail_inc && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_WIDTH'(1);
            end

            if (w_clr_timer)
                r_timer <= '0;
            else if (((r_state == WAIT_HDR) || (r_state == RECV)) && (r_timer != '1))
                r_timer <= r_timer + TIMER_WIDTH'(1);

            // Counts the cycles already spent in RST; restarts on every entry.
            if (r_state != RST) r_rst_cnt <= '0;
            else                r_rst_cnt <= r_rst_cnt + RC_W'(1);
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (w_start_nxt) r_pkt_len <= pkt_len;
    end

    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign pkt_start  = r_pkt_start;
    assign pkt_done   = r_pkt_done;
    assign pkt_status = r_pkt_status;
    assign ok_cnt     = r_ok_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Bench for rx_pkt_ctrl: directed packet scenarios, a cycle-level behavioural model compared
// on every clock, and literal expectations for the key scenarios.
module tb_rx_pkt_ctrl;

    localparam int CW      = 8;
    localparam int TW      = 20;
    localparam int RST_CYC = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          enable, sw_abort, cnt_clr;
    logic          preamble, hstrobe, hvalid, ht, fcs_strobe, fcs_ok;
    logic [15:0]   pkt_len, byte_count;
    logic [TW-1:0] hdr_th, pkt_th;
    logic          core_rst, busy, pkt_start, pkt_done;
    logic [2:0]    pkt_status;
    logic [CW-1:0] ok_cnt, fail_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_done   = 0;
    int n_core   = 0;

    rx_pkt_ctrl #(.CNT_WIDTH(CW), .TIMER_WIDTH(TW), .RST_CYCLES(RST_CYC)) dut (
        .s00_axi_aclk           (clk),
        .s00_axi_aresetn        (rst_n),
        .enable                 (enable),
        .sw_abort               (sw_abort),
        .cnt_clr                (cnt_clr),
        .long_preamble_detected (preamble),
        .pkt_header_valid_strobe(hstrobe),
        .pkt_header_valid       (hvalid),
        .ht_unsupport           (ht),
        .fcs_out_strobe         (fcs_strobe),
        .fcs_ok                 (fcs_ok),
        .pkt_len                (pkt_len),
        .byte_count             (byte_count),
        .hdr_timeout_th         (hdr_th),
        .pkt_timeout_th         (pkt_th),
        .core_rst               (core_rst),
        .busy                   (busy),
        .pkt_start              (pkt_start),
        .pkt_done               (pkt_done),
        .pkt_status             (pkt_status),
        .ok_cnt                 (ok_cnt),
        .fail_cnt               (fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the packet is either waiting for its header, receiving, or the
    // receiver reset is counting down; m_age is the number of cycles spent in the phase.
    bit m_wait, m_recv, m_start, m_done;
    int m_rst_left, m_age, m_len, m_status, m_ok, m_fail;

    task m_end(input int code, input bit to_rst);
        m_status = code;
        m_done   = 1'b1;
        m_wait   = 1'b0;
        m_recv   = 1'b0;
        if (code == 1) begin
            if (m_ok < CMAX) m_ok++;
        end else if (m_fail < CMAX) begin
            m_fail++;
        end
        if (to_rst) m_rst_left = RST_CYC;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait = 0; m_recv = 0; m_start = 0; m_done = 0;
            m_rst_left = 0; m_age = 0; m_status = 0; m_ok = 0; m_fail = 0;
        end else begin
            m_start = 0;
            m_done  = 0;
            if (m_rst_left > 0) begin
                m_rst_left--;
            end else if (m_wait) begin
                if (sw_abort) m_end(6, 1);
                else if (hstrobe) begin
                    if (hvalid && !ht && pkt_len != 0) begin
                        m_wait = 0; m_recv = 1; m_start = 1; m_len = int'(pkt_len); m_age = 0;
                    end else m_end(3, 1);
                end else if (hdr_th != 0 && m_age == int'(hdr_th)) m_end(4, 1);
                else m_age++;
            end else if (m_recv) begin
                if (sw_abort) m_end(6, 1);
                else if (fcs_strobe) begin
                    if (int'(byte_count) != m_len) m_end(7, 0);
                    else if (fcs_ok)               m_end(1, 0);
                    else                           m_end(2, 0);
                end else if (pkt_th != 0 && m_age == int'(pkt_th)) m_end(5, 1);
                else m_age++;
            end else begin
                if (sw_abort) m_rst_left = RST_CYC;
                else if (preamble && enable) begin
                    m_wait = 1; m_age = 0;
                end
            end
            if (cnt_clr) begin
                m_ok = 0; m_fail = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("core_rst",   int'(core_rst),   int'(m_rst_left > 0));
        check("busy",       int'(busy),       int'(m_wait || m_recv));
        check("pkt_start",  int'(pkt_start),  int'(m_start));
        check("pkt_done",   int'(pkt_done),   int'(m_done));
        check("pkt_status", int'(pkt_status), m_status);
        check("ok_cnt",     int'(ok_cnt),     m_ok);
        check("fail_cnt",   int'(fail_cnt),   m_fail);
        if (pkt_start) n_start++;
        if (pkt_done)  n_done++;
        if (core_rst)  n_core++;
    end

    task automatic clear_mon();
        n_start = 0; n_done = 0; n_core = 0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy || core_rst) && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (i >= 50) check("wait_idle_bound", 0, 1);
    endtask

    task automatic start_pkt(input int len);
        wait_idle();
        preamble = 1'b1;
        @(negedge clk);
        preamble = 1'b0;
        hstrobe = 1'b1; hvalid = 1'b1; pkt_len = 16'(len);
        @(negedge clk);
        hstrobe = 1'b0; hvalid = 1'b0;
    endtask

    task automatic finish_pkt(input int bc, input bit ok);
        byte_count = 16'(bc); fcs_strobe = 1'b1; fcs_ok = ok;
        @(negedge clk);
        fcs_strobe = 1'b0; fcs_ok = 1'b0; byte_count = 16'd0;
    endtask

    task automatic bad_hdr(input bit v, input bit u, input int len);
        wait_idle();
        preamble = 1'b1;
        @(negedge clk);
        preamble = 1'b0;
        hstrobe = 1'b1; hvalid = v; ht = u; pkt_len = 16'(len);
        @(negedge clk);
        hstrobe = 1'b0; hvalid = 1'b0; ht = 1'b0;
    endtask

    task automatic fail_once();
        wait_idle();
        preamble = 1'b1;
        @(negedge clk);
        preamble = 1'b0; sw_abort = 1'b1;
        @(negedge clk);
        sw_abort = 1'b0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; enable = 1'b1; sw_abort = 0; cnt_clr = 0;
        preamble = 0; hstrobe = 0; hvalid = 0; ht = 0; fcs_strobe = 0; fcs_ok = 0;
        pkt_len = 0; byte_count = 0; hdr_th = '0; pkt_th = '0;
        repeat (3) @(negedge clk);
        check("rst_core_rst", int'(core_rst), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_status", int'(pkt_status), 0);
        check("rst_ok_cnt", int'(ok_cnt), 0);
        check("rst_fail_cnt", int'(fail_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good 100-byte packet, with a stray preamble mid-packet
        clear_mon();
        start_pkt(100);
        check("t1_start", int'(pkt_start), 1);
        check("t1_busy", int'(busy), 1);
        for (int b = 1; b <= 100; b++) begin
            byte_count = 16'(b);
            preamble = (b == 50);
            @(negedge clk);
        end
        preamble = 1'b0;
        finish_pkt(100, 1'b1);
        check("t1_done", int'(pkt_done), 1);
        check("t1_status", int'(pkt_status), 1);
        check("t1_ok_cnt", int'(ok_cnt), 1);
        check("t1_busy_after", int'(busy), 0);
        check("t1_n_start", n_start, 1);
        check("t1_n_done", n_done, 1);
        check("t1_core_rst_cycles", n_core, 0);

        // Bad headers
        clear_mon();
        bad_hdr(1'b0, 1'b0, 100);
        check("t2_done", int'(pkt_done), 1);
        check("t2_status", int'(pkt_status), 3);
        check("t2_fail_cnt", int'(fail_cnt), 1);
        repeat (6) @(negedge clk);
        check("t2_core_rst_cycles", n_core, 4);
        check("t2_core_rst_low", int'(core_rst), 0);
        bad_hdr(1'b1, 1'b1, 100);
        check("t2_ht_status", int'(pkt_status), 3);
        bad_hdr(1'b1, 1'b0, 0);
        check("t2_len0_fail_cnt", int'(fail_cnt), 3);

        // Header timeout: core_rst must rise 51 cycles after WAIT_HDR entry
        hdr_th = 20'd50;
        wait_idle();
        preamble = 1'b1;
        @(posedge clk);
        @(negedge clk);
        preamble = 1'b0;
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (core_rst) break;
        end
        check("t3_hdr_to_latency", k, 51);
        check("t3_status", int'(pkt_status), 4);
        check("t3_fail_cnt", int'(fail_cnt), 4);
        @(negedge clk);
        wait_idle();
        preamble = 1'b1;
        @(negedge clk);
        preamble = 1'b0;
        repeat (50) @(negedge clk);
        hstrobe = 1'b1; hvalid = 1'b1; pkt_len = 16'd20;
        @(negedge clk);
        hstrobe = 1'b0; hvalid = 1'b0;
        check("t3_strobe_wins_start", int'(pkt_start), 1);
        check("t3_strobe_wins_core_rst", int'(core_rst), 0);
        finish_pkt(20, 1'b1);
        check("t3_ok_cnt", int'(ok_cnt), 2);
        hdr_th = '0;

        // Length error and FCS failure
        start_pkt(100);
        finish_pkt(99, 1'b1);
        check("t4_len_err_status", int'(pkt_status), 7);
        check("t4_len_err_fail_cnt", int'(fail_cnt), 5);
        start_pkt(100);
        finish_pkt(100, 1'b0);
        check("t4_fcs_fail_status", int'(pkt_status), 2);

        // Abort from IDLE (repeated during RST) keeps status and gives 4 reset cycles
        clear_mon();
        wait_idle();
        sw_abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sw_abort = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_idle_abort_status", int'(pkt_status), 2);
        check("t4_idle_abort_done", n_done, 0);
        check("t4_idle_abort_core_rst", n_core, 4);

        // Packet timeout, with and without a coincident FCS strobe
        pkt_th = 20'd10;
        start_pkt(30);
        repeat (10) @(negedge clk);
        finish_pkt(30, 1'b1);
        check("t4_fcs_wins_status", int'(pkt_status), 1);
        check("t4_fcs_wins_ok_cnt", int'(ok_cnt), 3);
        start_pkt(30);
        repeat (11) @(negedge clk);
        check("t4_pkt_to_done", int'(pkt_done), 1);
        check("t4_pkt_to_status", int'(pkt_status), 5);
        pkt_th = '0;

        // Abort beats a same-cycle FCS strobe
        start_pkt(10);
        sw_abort = 1'b1;
        finish_pkt(10, 1'b1);
        sw_abort = 1'b0;
        check("t4_abort_status", int'(pkt_status), 6);
        check("t4_abort_fail_cnt", int'(fail_cnt), 8);

        // Enable dropped mid-packet
        start_pkt(10);
        enable = 1'b0;
        finish_pkt(10, 1'b1);
        check("t4_en_off_ok_cnt", int'(ok_cnt), 4);
        preamble = 1'b1;
        @(negedge clk);
        preamble = 1'b0;
        @(negedge clk);
        check("t4_en_off_busy", int'(busy), 0);
        enable = 1'b1;

        // Saturation, then clear racing a failure
        for (int i = 0; i < 260; i++) fail_once();
        check("t5_fail_sat", int'(fail_cnt), CMAX);
        wait_idle();
        preamble = 1'b1;
        @(negedge clk);
        preamble = 1'b0; sw_abort = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        sw_abort = 1'b0; cnt_clr = 1'b0;
        check("t5_clr_done", int'(pkt_done), 1);
        check("t5_clr_fail_cnt", int'(fail_cnt), 0);
        check("t5_clr_ok_cnt", int'(ok_cnt), 0);

        // Asynchronous reset while receiving
        start_pkt(50);
        rst_n = 1'b0;
        #1;
        check("t5_areset_busy", int'(busy), 0);
        check("t5_areset_start", int'(pkt_start), 0);
        check("t5_areset_status", int'(pkt_status), 0);
        check("t5_areset_core_rst", int'(core_rst), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk);
        check("t5_areset_no_done", n_done, 0);
        check("t5_areset_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
